// File: rtl/mmio_responder.sv
// MMIO responder beside the data cache: UART status/data, cycle and retire counters.
// Latency: loads return rdata/mmio_sel_q one cycle after issue; stores take effect at the next edge.
// Backpressure: rx_ready drops when the receive FIFO is full; a TX write is dropped while a byte is pending.
module mmio_responder #(
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        mmio_sel_q,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW = $clog2(RX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RX_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  logic        sel;
  logic [7:0]  off;
  logic        is_wr;
  logic        is_rd;
  logic        unused_ok;

  logic [7:0]  rx_mem [RX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   rx_cnt;
  logic        rx_nonempty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  logic        tx_wr;
  logic        cnt_clr;
  logic [31:0] cyc_cnt;
  logic [31:0] inst_cnt;
  logic [31:0] rd_next;

  // Address decode: store wins over load, word-granular offsets
  assign sel       = (addr[31:28] == 4'h8);
  assign off       = {addr[7:2], 2'b00};
  assign is_wr     = we && sel;
  assign is_rd     = re && !we && sel;
  assign unused_ok = ^{addr[27:8], addr[1:0], wdata[31:8]};

  assign rx_nonempty = (rx_cnt != '0);
  assign fifo_full   = (rx_cnt == FULL_CNT);
  assign rx_ready    = !fifo_full && !reset;
  assign push        = rx_valid && rx_ready;
  assign pop         = is_rd && (off == OFF_RXDATA) && rx_nonempty;

  assign tx_wr   = is_wr && (off == OFF_TXDATA) && !tx_valid;
  assign cnt_clr = is_wr && (off == OFF_CLEAR);

  // Read mux: samples pre-edge state; anything not a selected load returns 0
  always_comb begin
    rd_next = '0;
    if (is_rd) begin
      case (off)
        OFF_STATUS: rd_next = {30'b0, rx_nonempty, !tx_valid};
        OFF_RXDATA: rd_next = rx_nonempty ? {24'h0, rx_mem[rd_ptr]} : 32'h0;
        OFF_CYCLE:  rd_next = cyc_cnt;
        OFF_INSTR:  rd_next = inst_cnt;
        default:    rd_next = '0;
      endcase
    end
  end

  // Registered load response for the stage-M select
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata      <= '0;
      mmio_sel_q <= 1'b0;
    end else begin
      rdata      <= rd_next;
      mmio_sel_q <= is_rd;
    end
  end

  // Receive FIFO storage; contents are meaningless until counted as occupied
  always_ff @(posedge clk) begin
    if (push) rx_mem[wr_ptr] <= rx_data;
  end

  // Receive FIFO pointers and occupancy; simultaneous push and pop leaves occupancy alone
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      rx_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      rx_cnt <= rx_cnt + (PW+1)'(1);
      else if (pop && !push) rx_cnt <= rx_cnt - (PW+1)'(1);
    end
  end

  // Single-entry transmit holding register; a write only lands when nothing is pending
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      if (tx_valid && tx_ready) tx_valid <= 1'b0;
      if (tx_wr) begin
        tx_valid <= 1'b1;
        tx_data  <= wdata[7:0];
      end
    end
  end

  // Free-running cycle and retired-instruction counters; clear beats increment
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        inst_retire;
  logic [31:0] rdata;
  logic        mmio_sel_q;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int n_checks = 0;
  int n_fails  = 0;

  mmio_responder #(.RX_DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .addr        (addr),
    .wdata       (wdata),
    .we          (we),
    .re          (re),
    .inst_retire (inst_retire),
    .rdata       (rdata),
    .mmio_sel_q  (mmio_sel_q),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    addr = 32'h0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    addr  = 32'h0;
    wdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    n_checks++; if (mmio_sel_q !== 1'b0) begin n_fails++; $display("FAIL reset_sel: got %b want 0", mmio_sel_q); end
    n_checks++; if (tx_data !== 8'h0) begin n_fails++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (rx_ready !== 1'b0) begin n_fails++; $display("FAIL reset_rx_ready_hi: got %b want 0", rx_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (rx_ready !== 1'b1) begin n_fails++; $display("FAIL reset_rx_ready_after: got %b want 1", rx_ready); end
    // Load issued in the first cycle after deassert sees the counter at 0
    do_load(32'h8000_0010);
    n_checks++; if (rdata !== 32'd0) begin n_fails++; $display("FAIL reset_cyc0: got %h want %h", rdata, 32'd0); end
    n_checks++; if (mmio_sel_q !== 1'b1) begin n_fails++; $display("FAIL reset_cyc0_sel: got %b want 1", mmio_sel_q); end
    tick();
    tick();
    do_load(32'h8000_0010);
    n_checks++; if (rdata !== 32'd3) begin n_fails++; $display("FAIL reset_cyc3: got %h want %h", rdata, 32'd3); end
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    do_store(32'h8000_0008, 32'h141);
    n_checks++; if (tx_valid !== 1'b1) begin n_fails++; $display("FAIL tx_set_valid: got %b want 1", tx_valid); end
    n_checks++; if (tx_data !== 8'h41) begin n_fails++; $display("FAIL tx_set_data: got %h want 41", tx_data); end
    do_store(32'h8000_0008, 32'h42);
    n_checks++; if (tx_data !== 8'h41) begin n_fails++; $display("FAIL tx_drop: got %h want 41", tx_data); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL tx_status_busy: got %h want %h", rdata, 32'h0); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL tx_handshake: got %b want 0", tx_valid); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h1) begin n_fails++; $display("FAIL tx_status_free: got %h want %h", rdata, 32'h1); end
    do_store(32'h8000_0008, 32'h42);
    n_checks++; if (tx_data !== 8'h42) begin n_fails++; $display("FAIL tx_second: got %h want 42", tx_data); end
    // Write while pending with tx_ready high: handshake completes, write still dropped
    tx_ready = 1'b1;
    do_store(32'h8000_0008, 32'h43);
    tx_ready = 1'b0;
    n_checks++; if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL tx_drop_rdy_valid: got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h42) begin n_fails++; $display("FAIL tx_drop_rdy_data: got %h want 42", tx_data); end
    // Unselected store to the TX offset does nothing
    do_store(32'h0000_0008, 32'h55);
    n_checks++; if (tx_valid !== 1'b0) begin n_fails++; $display("FAIL tx_unsel: got %b want 0", tx_valid); end
  endtask

  task automatic test_rx_fifo();
    logic [7:0] bytes [4];
    bytes[0] = 8'hA1; bytes[1] = 8'hA2; bytes[2] = 8'hA3; bytes[3] = 8'hA4;
    for (int i = 0; i < 4; i++) begin
      rx_data  = bytes[i];
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    n_checks++; if (rx_ready !== 1'b0) begin n_fails++; $display("FAIL rx_full: got %b want 0", rx_ready); end
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    n_checks++; if (rx_ready !== 1'b0) begin n_fails++; $display("FAIL rx_held_off: got %b want 0", rx_ready); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h3) begin n_fails++; $display("FAIL rx_status_full: got %h want %h", rdata, 32'h3); end
    for (int i = 0; i < 4; i++) begin
      do_load(32'h8000_0004);
      n_checks++; if (rdata !== {24'h0, bytes[i]}) begin n_fails++; $display("FAIL rx_pop%0d: got %h want %h", i, rdata, {24'h0, bytes[i]}); end
      if (i == 0) begin
        n_checks++; if (rx_ready !== 1'b1) begin n_fails++; $display("FAIL rx_ready_after_pop: got %b want 1", rx_ready); end
      end
    end
    do_load(32'h8000_0004);
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL rx_pop_empty: got %h want %h", rdata, 32'h0); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h1) begin n_fails++; $display("FAIL rx_status_empty: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_pop_push();
    rx_data  = 8'hB5;
    rx_valid = 1'b1;
    tick();
    rx_data  = 8'hB0;
    do_load(32'h8000_0004);
    rx_valid = 1'b0;
    n_checks++; if (rdata !== 32'hB5) begin n_fails++; $display("FAIL pp_pop: got %h want %h", rdata, 32'hB5); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h3) begin n_fails++; $display("FAIL pp_status_one: got %h want %h", rdata, 32'h3); end
    do_load(32'h8000_0004);
    n_checks++; if (rdata !== 32'hB0) begin n_fails++; $display("FAIL pp_next: got %h want %h", rdata, 32'hB0); end
    do_load(32'h8000_0000);
    n_checks++; if (rdata !== 32'h1) begin n_fails++; $display("FAIL pp_status_empty: got %h want %h", rdata, 32'h1); end
  endtask

  task automatic test_counters();
    for (int i = 0; i < 5; i++) begin
      inst_retire = 1'b1;
      tick();
      inst_retire = 1'b0;
      tick();
    end
    do_load(32'h8000_0014);
    n_checks++; if (rdata !== 32'd5) begin n_fails++; $display("FAIL cnt_inst5: got %h want %h", rdata, 32'd5); end
    inst_retire = 1'b1;
    do_store(32'h8000_0018, 32'hDEAD_BEEF);
    inst_retire = 1'b0;
    do_load(32'h8000_0014);
    n_checks++; if (rdata !== 32'd0) begin n_fails++; $display("FAIL cnt_inst_clr: got %h want %h", rdata, 32'd0); end
    do_load(32'h8000_0010);
    n_checks++; if (rdata !== 32'd1) begin n_fails++; $display("FAIL cnt_cyc_clr: got %h want %h", rdata, 32'd1); end
  endtask

  task automatic test_decode();
    do_load(32'h0000_1000);
    n_checks++; if (mmio_sel_q !== 1'b0) begin n_fails++; $display("FAIL dec_unsel_sel: got %b want 0", mmio_sel_q); end
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL dec_unsel_rdata: got %h want %h", rdata, 32'h0); end
    do_load(32'h8000_001C);
    n_checks++; if (mmio_sel_q !== 1'b1) begin n_fails++; $display("FAIL dec_1c_sel: got %b want 1", mmio_sel_q); end
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL dec_1c_rdata: got %h want %h", rdata, 32'h0); end
    // we and re together is a store: no load response
    addr = 32'h8000_0010; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0; addr = 32'h0;
    n_checks++; if (mmio_sel_q !== 1'b0) begin n_fails++; $display("FAIL dec_we_re_sel: got %b want 0", mmio_sel_q); end
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL dec_we_re_rdata: got %h want %h", rdata, 32'h0); end
  endtask

  task automatic test_wrap();
    force dut.inst_cnt = 32'hFFFF_FFFF;
    // Low address bits ignored: 0x17 decodes as the instruction counter
    do_load(32'h8000_0017);
    n_checks++; if (rdata !== 32'hFFFF_FFFF) begin n_fails++; $display("FAIL wrap_max: got %h want %h", rdata, 32'hFFFF_FFFF); end
    inst_retire = 1'b1;
    release dut.inst_cnt;
    tick();
    inst_retire = 1'b0;
    do_load(32'h8000_0014);
    n_checks++; if (rdata !== 32'h0) begin n_fails++; $display("FAIL wrap_zero: got %h want %h", rdata, 32'h0); end
  endtask

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
    inst_retire = 1'b0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    test_reset();
    test_tx();
    test_rx_fifo();
    test_pop_push();
    test_counters();
    test_decode();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
